// File: rtl/param_bank.sv
`default_nettype none
// ============================================================================
// Module   : param_bank
// Purpose  : Double-buffered 60-byte parameter frame store with sequence-checked
//            commit and renderer-synchronised swap. Optional PARAM_BANK_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module param_bank #(
   parameter int NBYTES = 60,
   parameter int IDXW   = 7,
   parameter int AW     = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic [IDXW-1:0] wr_idx,
   input  logic [7:0]      wr_data,
   input  logic            frame_done,
   input  logic            swap_req,
   input  logic [AW-1:0]   rd_addr,
   output logic [15:0]     rd_data,
   output logic            frame_valid,
   output logic            pending,
   output logic            seq_err,
   output logic [7:0]      frames_committed
);
   localparam int NWORDS = NBYTES / 2;
   localparam int BW     = $clog2(NBYTES);
   localparam logic [IDXW-1:0] C_NBYTES = IDXW'(NBYTES);
   localparam logic [IDXW-1:0] C_ONE    = IDXW'(1);
   localparam logic [AW:0]     C_NWORDS = (AW+1)'(NWORDS);

   logic [7:0]      r_bank0 [0:NBYTES-1];
   logic [7:0]      r_bank1 [0:NBYTES-1];
   logic            r_front;
   logic            r_pending;
   logic            r_frame_valid;
   logic            r_seq_err;
   logic [7:0]      r_frames;
   logic [IDXW-1:0] r_exp;
   logic            r_ferr;
   logic [15:0]     r_rd_data;

   logic            w_swap;
   logic            w_front_nxt;
   logic            w_idx_ok;
   logic [BW-1:0]   w_wr_byte;
   logic            w_csum_ok;
   logic            w_commit_ok;
   logic [IDXW-1:0] w_exp_nxt;
   logic            w_ferr_nxt;
   logic            w_pending_nxt;
   logic            w_rd_in_range;
   logic [AW-1:0]   w_ra;
   logic [BW-1:0]   w_rd_lo;
   logic [BW-1:0]   w_rd_hi;
   logic [15:0]     w_rd_word;

   // Front select after this edge; both the write target and the read source follow it.
   assign w_swap      = swap_req & r_pending;
   assign w_front_nxt = r_front ^ w_swap;
   assign w_idx_ok    = (wr_idx < C_NBYTES);
   assign w_wr_byte   = BW'(wr_idx);
   assign w_commit_ok = ~r_ferr & (r_exp == C_NBYTES) & w_csum_ok;

`ifdef PARAM_BANK_CHECKSUM_EN
   localparam logic [IDXW-1:0] C_LAST = IDXW'(NBYTES - 1);
   logic [7:0] r_csum;
   logic [7:0] r_last;
   logic [7:0] w_csum_nxt;
   logic [7:0] w_last_nxt;

   always_comb begin
      w_csum_nxt = r_csum;
      w_last_nxt = r_last;
      if (wr_en) begin
         if (wr_idx == '0)
            w_csum_nxt = wr_data;
         else if (wr_idx < C_LAST)
            w_csum_nxt = r_csum ^ wr_data;
         else if (wr_idx == C_LAST)
            w_last_nxt = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_csum <= 8'h00;
         r_last <= 8'h00;
      end else begin
         r_csum <= w_csum_nxt;
         r_last <= w_last_nxt;
      end
   end

   assign w_csum_ok = (r_last == r_csum);
`else
   assign w_csum_ok = 1'b1;
`endif

   always_comb begin
      w_exp_nxt     = r_exp;
      w_ferr_nxt    = r_ferr;
      w_pending_nxt = r_pending;
      if (frame_done) begin
         w_exp_nxt  = '0;
         w_ferr_nxt = 1'b0;
      end
      if (wr_en) begin
         if (wr_idx == '0) begin
            w_exp_nxt  = C_ONE;
            w_ferr_nxt = 1'b0;
         end else begin
            if (wr_idx == r_exp)
               w_exp_nxt = r_exp + C_ONE;
            else
               w_ferr_nxt = 1'b1;
            if (!w_idx_ok)
               w_ferr_nxt = 1'b1;
         end
      end
      // A fresh idx-0 start supersedes an unswapped frame; a new commit wins last.
      if (w_swap)
         w_pending_nxt = 1'b0;
      if (wr_en && (wr_idx == '0))
         w_pending_nxt = 1'b0;
      if (frame_done && w_commit_ok)
         w_pending_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_front       <= 1'b0;
         r_pending     <= 1'b0;
         r_frame_valid <= 1'b0;
         r_seq_err     <= 1'b0;
         r_frames      <= 8'h00;
         r_exp         <= '0;
         r_ferr        <= 1'b0;
         r_rd_data     <= 16'h0000;
      end else begin
         r_front   <= w_front_nxt;
         r_pending <= w_pending_nxt;
         r_seq_err <= frame_done & ~w_commit_ok;
         r_exp     <= w_exp_nxt;
         r_ferr    <= w_ferr_nxt;
         r_rd_data <= w_rd_in_range ? w_rd_word : 16'h0000;
         if (w_swap) begin
            r_frame_valid <= 1'b1;
            r_frames      <= r_frames + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_en && w_idx_ok) begin
         if (w_front_nxt)
            r_bank0[w_wr_byte] <= wr_data;
         else
            r_bank1[w_wr_byte] <= wr_data;
      end
   end

   assign w_rd_in_range = ({1'b0, rd_addr} < C_NWORDS);
   assign w_ra          = w_rd_in_range ? rd_addr : '0;
   assign w_rd_lo       = BW'({w_ra, 1'b0});
   assign w_rd_hi       = BW'({w_ra, 1'b1});
   assign w_rd_word     = w_front_nxt ? {r_bank1[w_rd_hi], r_bank1[w_rd_lo]}
                                      : {r_bank0[w_rd_hi], r_bank0[w_rd_lo]};

   assign rd_data          = r_rd_data;
   assign frame_valid      = r_frame_valid;
   assign pending          = r_pending;
   assign seq_err          = r_seq_err;
   assign frames_committed = r_frames;
endmodule
`default_nettype wire

// File: tb/tb_param_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_bank
// Purpose  : Scoreboard bench for param_bank; expectations queued by stimulus,
//            checked by an independent monitor. Honours PARAM_BANK_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module tb_param_bank;
   localparam int NB = 60;
   localparam int IW = 7;
   localparam int AW = 5;

   logic          clk;
   logic          reset;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [7:0]    wr_data;
   logic          frame_done;
   logic          swap_req;
   logic [AW-1:0] rd_addr;
   logic [15:0]   rd_data;
   logic          frame_valid;
   logic          pending;
   logic          seq_err;
   logic [7:0]    frames_committed;

   param_bank #(.NBYTES(NB), .IDXW(IW), .AW(AW)) dut (
      .clk              (clk),
      .reset            (reset),
      .wr_en            (wr_en),
      .wr_idx           (wr_idx),
      .wr_data          (wr_data),
      .frame_done       (frame_done),
      .swap_req         (swap_req),
      .rd_addr          (rd_addr),
      .rd_data          (rd_data),
      .frame_valid      (frame_valid),
      .pending          (pending),
      .seq_err          (seq_err),
      .frames_committed (frames_committed)
   );

   typedef struct {
      int          kind;   // 0: rd_data, 1: {frame_valid,pending,frames_committed}, 2: seq_err pulses
      logic [31:0] exp;
      int          due;
      string       name;
   } item_t;

   item_t       sb[$];
   int          cyc = 0;
   int          seq_seen = 0;
   int          vectors = 0;
   int          miscompares = 0;
   item_t       it_m;
   logic [31:0] act;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (seq_err === 1'b1) seq_seen = seq_seen + 1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         it_m = sb.pop_front();
         case (it_m.kind)
            0:       act = {16'h0000, rd_data};
            1:       act = {22'h0, frame_valid, pending, frames_committed};
            default: act = seq_seen;
         endcase
         vectors = vectors + 1;
         if (act !== it_m.exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h, expected %0h", it_m.name, act, it_m.exp);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int kind, input logic [31:0] e, input int due, input string n);
      item_t it;
      it.kind = kind;
      it.exp  = e;
      it.due  = due;
      it.name = n;
      sb.push_back(it);
   endtask

   task automatic exp_status(input logic fv, input logic p, input logic [7:0] fc, input string n);
      push(1, {22'h0, fv, p, fc}, cyc, n);
   endtask

   task automatic exp_seq(input int cnt, input string n);
      push(2, cnt, cyc, n);
   endtask

   task automatic read_chk(input logic [AW-1:0] a, input logic [15:0] e, input string n);
      rd_addr = a;
      push(0, {16'h0000, e}, cyc + 1, n);
      step();
   endtask

   task automatic write_byte(input int idx, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_idx  = IW'(idx);
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   // Bytes are key^k, so byte NB-1 equals the XOR of bytes 0..NB-2 unless bad_last.
   task automatic write_frame(input logic [7:0] key, input int skip, input int stop, input logic bad_last);
      logic [7:0] d;
      for (int k = 0; k <= stop; k++) begin
         if (k != skip) begin
            d = key ^ 8'(k);
            if (bad_last && k == NB - 1) d = d ^ 8'h01;
            write_byte(k, d);
         end
      end
   endtask

   task automatic done_pulse();
      step();
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
   endtask

   task automatic swap_pulse();
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = 8'h00;
      frame_done = 1'b0; swap_req = 1'b0; rd_addr = '0;
      step(); step();
      exp_status(1'b0, 1'b0, 8'd0, "reset_status");
      push(0, 32'h0, cyc, "reset_rd_data");
      reset = 1'b0;
      step();
      exp_seq(0, "reset_seq_err");

      // Frame k->k, commit, swap, read back
      write_frame(8'h00, -1, NB - 1, 1'b0);
      done_pulse();
      exp_status(1'b0, 1'b1, 8'd0, "a_pending");
      swap_pulse();
      exp_status(1'b1, 1'b0, 8'd1, "a_swapped");
      read_chk(5'd0,  16'h0100, "a_rd0");
      read_chk(5'd29, 16'h3B3A, "a_rd29");
      read_chk(5'd30, 16'h0000, "a_rd30_oob");
      read_chk(5'd31, 16'h0000, "a_rd31_oob");

      // Second frame 0xFF-k stays in back until swap; read in swap cycle sees new front
      write_frame(8'hFF, -1, NB - 1, 1'b0);
      done_pulse();
      exp_status(1'b1, 1'b1, 8'd1, "ff_pending");
      read_chk(5'd0, 16'h0100, "ff_front_held");
      rd_addr  = 5'd0;
      swap_req = 1'b1;
      push(0, 32'h0000FEFF, cyc + 1, "ff_rd_in_swap_cycle");
      step();
      swap_req = 1'b0;
      exp_status(1'b1, 1'b0, 8'd2, "ff_swapped");

      // Skipped index 10
      write_frame(8'h00, 10, NB - 1, 1'b0);
      done_pulse();
      exp_seq(1, "skip_seq_err");
      exp_status(1'b1, 1'b0, 8'd2, "skip_status");
      read_chk(5'd0, 16'hFEFF, "skip_front_intact");

      // Stale pending frame superseded by a new idx-0 start
      write_frame(8'h00, -1, NB - 1, 1'b0);
      done_pulse();
      exp_status(1'b1, 1'b1, 8'd2, "stale_a_pending");
      write_byte(0, 8'h80);
      exp_status(1'b1, 1'b0, 8'd2, "stale_cleared");
      for (int k = 1; k < NB; k++) write_byte(k, 8'h80 ^ 8'(k));
      done_pulse();
      exp_status(1'b1, 1'b1, 8'd2, "b_pending");
      swap_pulse();
      exp_status(1'b1, 1'b0, 8'd3, "b_swapped");
      read_chk(5'd0,  16'h8180, "b_rd0");
      read_chk(5'd29, 16'hBBBA, "b_rd29");
      exp_seq(1, "stale_no_seq_err");

      // frame_done and swap_req together while nothing pending
      write_frame(8'h33, -1, NB - 1, 1'b0);
      step();
      frame_done = 1'b1;
      swap_req   = 1'b1;
      step();
      frame_done = 1'b0;
      swap_req   = 1'b0;
      exp_status(1'b1, 1'b1, 8'd3, "simul_no_swap");
      read_chk(5'd0, 16'h8180, "simul_front_held");
      swap_pulse();
      exp_status(1'b1, 1'b0, 8'd4, "simul_next_swap");
      read_chk(5'd0, 16'h3233, "simul_rd0");

      // Reset mid-frame, then a full frame
      write_frame(8'h00, -1, 30, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_status(1'b0, 1'b0, 8'd0, "midreset_status");
      push(0, 32'h0, cyc, "midreset_rd_data");
      write_frame(8'h00, -1, NB - 1, 1'b0);
      done_pulse();
      exp_status(1'b0, 1'b1, 8'd0, "post_reset_pending");
      swap_pulse();
      exp_status(1'b1, 1'b0, 8'd1, "post_reset_swapped");
      read_chk(5'd0, 16'h0100, "post_reset_rd0");

      // Wrong last byte: rejected only with the checksum feature
      write_frame(8'h00, -1, NB - 1, 1'b1);
      done_pulse();
`ifdef PARAM_BANK_CHECKSUM_EN
      exp_seq(2, "cksum_seq_err");
      exp_status(1'b1, 1'b0, 8'd1, "cksum_status");
`else
      exp_seq(1, "lastbyte_seq_err");
      exp_status(1'b1, 1'b1, 8'd1, "lastbyte_status");
`endif

      // Out-of-range index poisons the frame
      write_frame(8'h00, -1, NB - 1, 1'b0);
      write_byte(NB, 8'hAA);
      done_pulse();
`ifdef PARAM_BANK_CHECKSUM_EN
      exp_seq(3, "oob_idx_seq_err");
`else
      exp_seq(2, "oob_idx_seq_err");
`endif
      exp_status(1'b1, 1'b0, 8'd1, "oob_idx_status");
      read_chk(5'd29, 16'h3B3A, "oob_front_intact");

      for (int i = 0; i < 5 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         $display("FAIL drain: %0d checks outstanding, expected 0", sb.size());
         miscompares = miscompares + sb.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
